// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone bus arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which master currently owns (or last owned) the bus
//   CTI_*       : Wishbone cycle-type identifiers used by burst masters
//   rr_pick     : round-robin choice between the two masters
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        ABORT   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // On a tie the master that did not own the bus last time wins.
    function automatic owner_t rr_pick(input logic req_i, input logic req_d,
                                       input owner_t last_owner);
        if (req_i && req_d) begin
            return (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
        end
        return req_d ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_arb_watchdog
// Counts stalled cycles of the current bus owner and flags when the slave
// has been silent for TIMEOUT_CYCLES consecutive strobed cycles.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_in_grant   : arbiter is in a GRANT state
//   i_stall      : owner strobe high and no slave ack/err this cycle
//   i_resp       : slave ack or err this cycle
//   o_fire       : combinational, high on the cycle the limit is reached
// -----------------------------------------------------------------------------
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in_grant,
    input  logic i_stall,
    input  logic i_resp,
    output logic o_fire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign o_fire = i_in_grant & i_stall & (r_count == LIMIT);

    // Cleared on firing too, so a stuck owner cannot wrap the counter.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_in_grant || i_resp || o_fire) begin
            r_count <= '0;
        end else if (i_stall) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Round-robin arbiter sharing one Wishbone slave port between an instruction
// master (ibus) and a data master (dbus), with a stall watchdog.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ibus_* / dbus_*          : master-side Wishbone ports (cyc/stb/we/adr/dat/
//                              sel/cti/bte in, ack/err/dat out)
//   s_*                      : shared slave-side Wishbone port
//   grant_o                  : one-hot {dbus,ibus} owner, 2'b00 when idle
//   timeout_o                : one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ibus_cyc_i,
    input  logic                    ibus_stb_i,
    input  logic                    ibus_we_i,
    input  logic [ADDR_WIDTH-1:0]   ibus_adr_i,
    input  logic [DATA_WIDTH-1:0]   ibus_dat_i,
    input  logic [DATA_WIDTH/8-1:0] ibus_sel_i,
    input  logic [2:0]              ibus_cti_i,
    input  logic [1:0]              ibus_bte_i,
    output logic                    ibus_ack_o,
    output logic                    ibus_err_o,
    output logic [DATA_WIDTH-1:0]   ibus_dat_o,

    input  logic                    dbus_cyc_i,
    input  logic                    dbus_stb_i,
    input  logic                    dbus_we_i,
    input  logic [ADDR_WIDTH-1:0]   dbus_adr_i,
    input  logic [DATA_WIDTH-1:0]   dbus_dat_i,
    input  logic [DATA_WIDTH/8-1:0] dbus_sel_i,
    input  logic [2:0]              dbus_cti_i,
    input  logic [1:0]              dbus_bte_i,
    output logic                    dbus_ack_o,
    output logic                    dbus_err_o,
    output logic [DATA_WIDTH-1:0]   dbus_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [2:0]              s_cti_o,
    output logic [1:0]              s_bte_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,

    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    arb_state_t r_state;
    owner_t     r_owner;
    owner_t     r_last_owner;
    logic [1:0] r_grant;

    logic   w_req_i;
    logic   w_req_d;
    owner_t w_pick;
    logic   w_in_grant;
    logic   w_sel_d;
    logic   w_own_cyc;
    logic   w_own_stb;
    logic   w_resp;
    logic   w_fire;

    assign w_req_i    = ibus_cyc_i & ibus_stb_i;
    assign w_req_d    = dbus_cyc_i & dbus_stb_i;
    assign w_pick     = rr_pick(w_req_i, w_req_d, r_last_owner);
    assign w_in_grant = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign w_sel_d    = (r_owner == OWNER_D);
    assign w_own_cyc  = w_sel_d ? dbus_cyc_i : ibus_cyc_i;
    assign w_own_stb  = w_sel_d ? dbus_stb_i : ibus_stb_i;
    assign w_resp     = s_ack_i | s_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_grant (w_in_grant),
        .i_stall    (w_own_stb & ~w_resp),
        .i_resp     (w_resp),
        .o_fire     (w_fire)
    );

    // Requests are only sampled in IDLE, which gives the one-cycle grant
    // latency and keeps master requests off the s_cyc_o path while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_I;
            r_last_owner <= OWNER_I;
            r_grant      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_i || w_req_d) begin
                        r_owner <= w_pick;
                        if (w_pick == OWNER_D) begin
                            r_state <= GRANT_D;
                            r_grant <= 2'b10;
                        end else begin
                            r_state <= GRANT_I;
                            r_grant <= 2'b01;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!w_own_cyc) begin
                        r_state      <= IDLE;
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                    end else if (w_fire) begin
                        r_state <= ABORT;
                    end
                end
                ABORT: begin
                    if (!w_own_cyc) begin
                        r_state      <= IDLE;
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (w_in_grant) begin
            if (w_sel_d) begin
                s_cyc_o = dbus_cyc_i;
                s_stb_o = dbus_stb_i;
                s_we_o  = dbus_we_i;
                s_adr_o = dbus_adr_i;
                s_dat_o = dbus_dat_i;
                s_sel_o = dbus_sel_i;
                s_cti_o = dbus_cti_i;
                s_bte_o = dbus_bte_i;
            end else begin
                s_cyc_o = ibus_cyc_i;
                s_stb_o = ibus_stb_i;
                s_we_o  = ibus_we_i;
                s_adr_o = ibus_adr_i;
                s_dat_o = ibus_dat_i;
                s_sel_o = ibus_sel_i;
                s_cti_o = ibus_cti_i;
                s_bte_o = ibus_bte_i;
            end
        end
    end

    // A watchdog fire reports as a bus error to the owner in the same cycle.
    assign ibus_ack_o = (r_state == GRANT_I) & ibus_stb_i & s_ack_i;
    assign ibus_err_o = (r_state == GRANT_I) & ibus_stb_i & (s_err_i | w_fire);
    assign dbus_ack_o = (r_state == GRANT_D) & dbus_stb_i & s_ack_i;
    assign dbus_err_o = (r_state == GRANT_D) & dbus_stb_i & (s_err_i | w_fire);
    assign ibus_dat_o = s_dat_i;
    assign dbus_dat_o = s_dat_i;

    assign grant_o   = r_grant;
    assign timeout_o = w_fire;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;
    import wb_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ibus_cyc_i, ibus_stb_i, ibus_we_i;
    logic [AW-1:0] ibus_adr_i;
    logic [DW-1:0] ibus_dat_i;
    logic [3:0]    ibus_sel_i;
    logic [2:0]    ibus_cti_i;
    logic [1:0]    ibus_bte_i;
    logic          ibus_ack_o, ibus_err_o;
    logic [DW-1:0] ibus_dat_o;
    logic          dbus_cyc_i, dbus_stb_i, dbus_we_i;
    logic [AW-1:0] dbus_adr_i;
    logic [DW-1:0] dbus_dat_i;
    logic [3:0]    dbus_sel_i;
    logic [2:0]    dbus_cti_i;
    logic [1:0]    dbus_bte_i;
    logic          dbus_ack_o, dbus_err_o;
    logic [DW-1:0] dbus_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic [2:0]    s_cti_o;
    logic [1:0]    s_bte_o;
    logic          s_ack_i, s_err_i;
    logic [DW-1:0] s_dat_i;
    logic [1:0]    grant_o;
    logic          timeout_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_cyc_i (ibus_cyc_i), .ibus_stb_i (ibus_stb_i), .ibus_we_i (ibus_we_i),
        .ibus_adr_i (ibus_adr_i), .ibus_dat_i (ibus_dat_i), .ibus_sel_i (ibus_sel_i),
        .ibus_cti_i (ibus_cti_i), .ibus_bte_i (ibus_bte_i),
        .ibus_ack_o (ibus_ack_o), .ibus_err_o (ibus_err_o), .ibus_dat_o (ibus_dat_o),
        .dbus_cyc_i (dbus_cyc_i), .dbus_stb_i (dbus_stb_i), .dbus_we_i (dbus_we_i),
        .dbus_adr_i (dbus_adr_i), .dbus_dat_i (dbus_dat_i), .dbus_sel_i (dbus_sel_i),
        .dbus_cti_i (dbus_cti_i), .dbus_bte_i (dbus_bte_i),
        .dbus_ack_o (dbus_ack_o), .dbus_err_o (dbus_err_o), .dbus_dat_o (dbus_dat_o),
        .s_cyc_o    (s_cyc_o),    .s_stb_o    (s_stb_o),    .s_we_o     (s_we_o),
        .s_adr_o    (s_adr_o),    .s_dat_o    (s_dat_o),    .s_sel_o    (s_sel_o),
        .s_cti_o    (s_cti_o),    .s_bte_o    (s_bte_o),
        .s_ack_i    (s_ack_i),    .s_err_i    (s_err_i),    .s_dat_i    (s_dat_i),
        .grant_o    (grant_o),
        .timeout_o  (timeout_o)
    );

    // Inputs change 1 time unit after the rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b10;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b10;

        rst = 1'b1;
        ibus_cyc_i = 0; ibus_stb_i = 0; ibus_we_i = 0; ibus_adr_i = '0;
        ibus_dat_i = '0; ibus_sel_i = '0; ibus_cti_i = '0; ibus_bte_i = '0;
        dbus_cyc_i = 0; dbus_stb_i = 0; dbus_we_i = 0; dbus_adr_i = '0;
        dbus_dat_i = '0; dbus_sel_i = '0; dbus_cti_i = '0; dbus_bte_i = '0;
        s_ack_i = 0; s_err_i = 0; s_dat_i = '0;

        // Reset state
        nxt(); nxt(); settle();
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_ibus_ack", ibus_ack_o, 0);
        chk("rst_dbus_ack", dbus_ack_o, 0);
        chk("rst_timeout", timeout_o, 0);

        // dbus read 0x100, slave acks two cycles after strobe
        nxt(); rst = 0;
        dbus_cyc_i = 1; dbus_stb_i = 1; dbus_we_i = 0; dbus_adr_i = 32'h100; dbus_sel_i = 4'hF;
        settle();
        chk("rd_idle_no_comb_cyc", s_cyc_o, 0);
        nxt(); settle();
        chk("rd_s_cyc", s_cyc_o, 1);
        chk("rd_s_adr", s_adr_o, 32'h100);
        chk("rd_grant", grant_o, 2'b10);
        chk("rd_early_ack", dbus_ack_o, 0);
        nxt(); settle();
        chk("rd_wait_ack", dbus_ack_o, 0);
        nxt(); s_ack_i = 1; s_dat_i = 32'hDEADBEEF; settle();
        chk("rd_dbus_ack", dbus_ack_o, 1);
        chk("rd_dbus_dat", dbus_dat_o, 32'hDEADBEEF);
        chk("rd_ibus_ack", ibus_ack_o, 0);
        nxt(); s_ack_i = 0; dbus_cyc_i = 0; dbus_stb_i = 0; settle();
        chk("rd_release_s_cyc", s_cyc_o, 0);
        nxt(); settle();
        chk("rd_idle_grant", grant_o, 2'b00);

        // dbus write 0x200 sel 0011, then reset before ack
        dbus_cyc_i = 1; dbus_stb_i = 1; dbus_we_i = 1; dbus_adr_i = 32'h200;
        dbus_sel_i = 4'b0011; dbus_dat_i = 32'h0000ABCD;
        nxt(); settle();
        chk("wr_s_we", s_we_o, 1);
        chk("wr_s_sel", s_sel_o, 4'b0011);
        chk("wr_s_dat", s_dat_o, 32'h0000ABCD);
        chk("wr_s_adr", s_adr_o, 32'h200);
        chk("wr_grant", grant_o, 2'b10);
        rst = 1;
        nxt(); s_ack_i = 1; settle();
        chk("wr_rst_s_cyc", s_cyc_o, 0);
        chk("wr_rst_grant", grant_o, 2'b00);
        chk("wr_rst_no_ack", dbus_ack_o, 0);
        rst = 0; s_ack_i = 0; dbus_cyc_i = 0; dbus_stb_i = 0; dbus_we_i = 0;

        // Simultaneous requests three times: dbus, ibus, dbus
        for (int i = 0; i < 3; i++) begin
            ibus_cyc_i = 1; ibus_stb_i = 1; dbus_cyc_i = 1; dbus_stb_i = 1;
            nxt(); s_ack_i = 1; settle();
            chk("rr_grant", grant_o, exp_g[i]);
            chk("rr_owner_ack", (exp_g[i] == 2'b10) ? dbus_ack_o : ibus_ack_o, 1);
            chk("rr_other_ack", (exp_g[i] == 2'b10) ? ibus_ack_o : dbus_ack_o, 0);
            nxt(); s_ack_i = 0;
            if (exp_g[i] == 2'b10) begin
                dbus_cyc_i = 0; dbus_stb_i = 0;
            end else begin
                ibus_cyc_i = 0; ibus_stb_i = 0;
            end
            settle();
            chk("rr_release_s_cyc", s_cyc_o, 0);
            nxt(); settle();
            chk("rr_idle_gap", grant_o, 2'b00);
        end
        ibus_cyc_i = 0; ibus_stb_i = 0; dbus_cyc_i = 0; dbus_stb_i = 0;
        nxt();

        // ibus 8-beat incrementing burst with a strobe gap; dbus asks at beat 2
        ibus_cyc_i = 1; ibus_stb_i = 1; ibus_we_i = 0; ibus_adr_i = '0; ibus_cti_i = CTI_INCR;
        dbus_we_i = 0; dbus_adr_i = 32'h300;
        for (int b = 0; b < 8; b++) begin
            if (b == 4) begin
                nxt(); ibus_stb_i = 0; s_ack_i = 0; settle();
                chk("bst_gap_s_cyc", s_cyc_o, 1);
                chk("bst_gap_s_stb", s_stb_o, 0);
                chk("bst_gap_grant", grant_o, 2'b01);
                chk("bst_gap_dbus_ack", dbus_ack_o, 0);
            end
            nxt();
            ibus_stb_i = 1; s_ack_i = 1;
            ibus_adr_i = 32'(b * 4);
            ibus_cti_i = (b == 7) ? CTI_EOB : CTI_INCR;
            if (b == 2) begin
                dbus_cyc_i = 1; dbus_stb_i = 1;
            end
            settle();
            chk("bst_ibus_ack", ibus_ack_o, 1);
            chk("bst_dbus_wait", dbus_ack_o, 0);
            chk("bst_grant", grant_o, 2'b01);
            chk("bst_s_adr", s_adr_o, 32'(b * 4));
            chk("bst_s_cti", s_cti_o, (b == 7) ? 3'b111 : 3'b010);
        end
        nxt(); ibus_cyc_i = 0; ibus_stb_i = 0; s_ack_i = 0; settle();
        chk("bst_end_s_cyc", s_cyc_o, 0);
        chk("bst_end_dbus_ack", dbus_ack_o, 0);
        nxt(); settle();
        chk("bst_idle_grant", grant_o, 2'b00);
        nxt(); s_ack_i = 1; settle();
        chk("bst_dbus_grant", grant_o, 2'b10);
        chk("bst_dbus_adr", s_adr_o, 32'h300);
        chk("bst_dbus_ack", dbus_ack_o, 1);
        nxt(); s_ack_i = 0; dbus_cyc_i = 0; dbus_stb_i = 0;
        nxt();

        // Watchdog: slave silent on an ibus read
        ibus_cyc_i = 1; ibus_stb_i = 1; ibus_adr_i = 32'h40; ibus_cti_i = CTI_CLASSIC;
        for (int k = 1; k <= 16; k++) begin
            nxt(); settle();
            if (k == 1 || k == 15) begin
                chk("wd_early_err", ibus_err_o, 0);
                chk("wd_early_timeout", timeout_o, 0);
            end
        end
        chk("wd_ibus_err", ibus_err_o, 1);
        chk("wd_timeout", timeout_o, 1);
        chk("wd_dbus_err", dbus_err_o, 0);
        nxt(); s_ack_i = 1; settle();
        chk("ab_s_cyc", s_cyc_o, 0);
        chk("ab_s_stb", s_stb_o, 0);
        chk("ab_grant", grant_o, 2'b01);
        chk("ab_late_ack", ibus_ack_o, 0);
        chk("ab_timeout_pulse", timeout_o, 0);
        nxt(); s_ack_i = 0; ibus_cyc_i = 0; ibus_stb_i = 0; settle();
        chk("ab_hold_s_cyc", s_cyc_o, 0);
        nxt(); settle();
        chk("ab_idle_grant", grant_o, 2'b00);

        // Slave error goes to the owner only and does not end the grant
        dbus_cyc_i = 1; dbus_stb_i = 1;
        nxt(); s_err_i = 1; settle();
        chk("err_dbus_err", dbus_err_o, 1);
        chk("err_ibus_err", ibus_err_o, 0);
        chk("err_dbus_ack", dbus_ack_o, 0);
        nxt(); s_err_i = 0; settle();
        chk("err_grant_held", grant_o, 2'b10);
        chk("err_s_cyc_held", s_cyc_o, 1);
        dbus_cyc_i = 0; dbus_stb_i = 0;
        nxt(); nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
